// File: rtl/cfu_arbiter_pkg.sv
// cfu_types: shared widths, payload structs and the response FSM state type
// used by the CFU arbiter and its round-robin sub-block.
//   cfu_req_t   request payload broadcast from the core to every CFU
//   cfu_resp_t  response payload returned by one CFU (or the local error slot)
package cfu_types;

   localparam int C_M_CFU_ID_W     = 4;
   localparam int C_M_CFU_CFU_W    = 3;
   localparam int C_M_CFU_STATE_W  = 2;
   localparam int C_M_CFU_FUNC_W   = 7;
   localparam int C_M_CFU_INSN_W   = 32;
   localparam int C_M_CFU_DATA_W   = 32;
   localparam int C_M_CFU_STATUS_W = 3;

   localparam logic [C_M_CFU_STATUS_W-1:0] CFU_STATUS_OK    = C_M_CFU_STATUS_W'(0);
   localparam logic [C_M_CFU_STATUS_W-1:0] CFU_STATUS_ERROR = C_M_CFU_STATUS_W'(2);

   typedef struct packed {
      logic [C_M_CFU_ID_W-1:0]    id;
      logic [C_M_CFU_CFU_W-1:0]   cfu;
      logic [C_M_CFU_STATE_W-1:0] state;
      logic [C_M_CFU_FUNC_W-1:0]  func;
      logic [C_M_CFU_INSN_W-1:0]  insn;
      logic [C_M_CFU_DATA_W-1:0]  data0;
      logic [C_M_CFU_DATA_W-1:0]  data1;
   } cfu_req_t;

   typedef struct packed {
      logic [C_M_CFU_ID_W-1:0]     id;
      logic [C_M_CFU_STATUS_W-1:0] status;
      logic [C_M_CFU_DATA_W-1:0]   data;
   } cfu_resp_t;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/cfu_arbiter_rr.sv
// cfu_rr_arbiter: round-robin picker over N request lines.
//   clk, rst  clock and synchronous active-high reset
//   req       request vector
//   lock      hold the previously presented grant instead of re-arbitrating
//   advance   grant consumed: pointer moves to grant+1 (mod N)
//   grant     one-hot grant (all zero when nothing requests and not locked)
//   idx       binary index of the grant
//   any       at least one request line is high
//   ptr       current round-robin pointer
module cfu_rr_arbiter #(
   parameter int N = 5,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          lock,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic [IW-1:0] ptr
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] held_q;
   logic [IW-1:0] pick_idx;
   logic          found;
   logic [IW:0]   cand;

   // First requesting line at or after the pointer, wrapping at N.
   always_comb begin
      pick_idx = '0;
      found    = 1'b0;
      cand     = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (!found && req[cand[IW-1:0]]) begin
            found    = 1'b1;
            pick_idx = cand[IW-1:0];
         end
      end
   end

   assign any = |req;
   assign idx = lock ? held_q : pick_idx;
   assign ptr = ptr_q;

   always_comb begin
      grant = '0;
      for (int i = 0; i < N; i++) grant[i] = (idx == IW'(i)) & (any | lock);
   end

   // held_q tracks the live pick until locked, so it already holds the
   // grant that was presented in the cycle the lock was taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         held_q <= '0;
      end else begin
         if (!lock) held_q <= pick_idx;
         if (advance) ptr_q <= (idx == IW'(N-1)) ? '0 : idx + IW'(1);
      end
   end

endmodule

// File: rtl/cfu_arbiter.sv
// cfu_arbiter: shares the core's single CFU request/response port among
// NUM_CFUS CFUs. Requests are steered by cpu_req_cfu; responses from the CFUs
// and from a one-entry local error slot are merged round-robin.
//   cpu_req_*   core request (valid/ready + payload)
//   cpu_resp_*  merged response to the core (valid/ready + id/status/data)
//   cfu_req_*   one-hot valid, per-CFU ready, broadcast payload
//   cfu_resp_*  per-CFU valid + payload, one-hot ready
//   dbg_*       response FSM state, outstanding count, round-robin pointer
// Handshakes: a transfer happens on a cycle where valid and ready are both 1
// at the rising edge; valid must not depend on ready, and a source holding
// valid keeps its payload stable until the transfer.
module cfu_arbiter
   import cfu_types::*;
#(
   parameter int NUM_CFUS        = 4,
   parameter int MAX_OUTSTANDING = 4,
   localparam int SW = $clog2(NUM_CFUS + 1),
   localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cpu_req_valid,
   output logic                        cpu_req_ready,
   input  logic [C_M_CFU_ID_W-1:0]     cpu_req_id,
   input  logic [C_M_CFU_CFU_W-1:0]    cpu_req_cfu,
   input  logic [C_M_CFU_STATE_W-1:0]  cpu_req_state,
   input  logic [C_M_CFU_FUNC_W-1:0]   cpu_req_func,
   input  logic [C_M_CFU_INSN_W-1:0]   cpu_req_insn,
   input  logic [C_M_CFU_DATA_W-1:0]   cpu_req_data0,
   input  logic [C_M_CFU_DATA_W-1:0]   cpu_req_data1,
   output logic                        cpu_resp_valid,
   input  logic                        cpu_resp_ready,
   output logic [C_M_CFU_ID_W-1:0]     cpu_resp_id,
   output logic [C_M_CFU_STATUS_W-1:0] cpu_resp_status,
   output logic [C_M_CFU_DATA_W-1:0]   cpu_resp_data,
   output logic [NUM_CFUS-1:0]         cfu_req_valid,
   input  logic [NUM_CFUS-1:0]         cfu_req_ready,
   output cfu_req_t                    cfu_req_payload,
   input  logic [NUM_CFUS-1:0]         cfu_resp_valid,
   output logic [NUM_CFUS-1:0]         cfu_resp_ready,
   input  cfu_resp_t                   cfu_resp_payload [NUM_CFUS],
   output arb_state_t                  dbg_state,
   output logic [CW-1:0]               dbg_count,
   output logic [SW-1:0]               dbg_ptr
);

   arb_state_t        state_q, state_d;
   logic [CW-1:0]     count_q;
   logic              err_full;
   cfu_resp_t         err_q;
   logic              room, sel_ok, sel_ready;
   logic              req_hs, resp_hs, err_load, err_pop;
   logic [NUM_CFUS:0] src_valid, grant;
   logic [SW-1:0]     grant_idx;
   logic              any_valid, locked, grant_valid;
   cfu_resp_t         resp_pay;

   assign cfu_req_payload = '{id: cpu_req_id, cfu: cpu_req_cfu, state: cpu_req_state,
                              func: cpu_req_func, insn: cpu_req_insn,
                              data0: cpu_req_data0, data1: cpu_req_data1};

   // Request steering; out-of-range CFU numbers are absorbed by the error slot.
   assign room   = count_q < CW'(MAX_OUTSTANDING);
   assign sel_ok = int'(cpu_req_cfu) < NUM_CFUS;

   always_comb begin
      cfu_req_valid = '0;
      sel_ready     = 1'b0;
      for (int i = 0; i < NUM_CFUS; i++) begin
         if (int'(cpu_req_cfu) == i) begin
            cfu_req_valid[i] = cpu_req_valid & room;
            sel_ready        = cfu_req_ready[i];
         end
      end
      cpu_req_ready = sel_ok ? (sel_ready & room) : (room & ~err_full);
      if (rst) begin
         cfu_req_valid = '0;
         cpu_req_ready = 1'b0;
      end
   end

   assign req_hs   = cpu_req_valid & cpu_req_ready;
   assign err_load = req_hs & ~sel_ok;

   // Response merge: the error slot is the highest-numbered source.
   assign src_valid = {err_full, cfu_resp_valid};
   assign locked    = (state_q == ARB_LOCKED);

   cfu_rr_arbiter #(.N(NUM_CFUS + 1)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (src_valid),
      .lock    (locked),
      .advance (resp_hs),
      .grant   (grant),
      .idx     (grant_idx),
      .any     (any_valid),
      .ptr     (dbg_ptr)
   );

   always_comb begin
      resp_pay = err_q;
      for (int i = 0; i < NUM_CFUS; i++) begin
         if (grant[i]) resp_pay = cfu_resp_payload[i];
      end
   end

   assign cpu_resp_valid  = ~rst & (any_valid | locked);
   assign cpu_resp_id     = resp_pay.id;
   assign cpu_resp_status = resp_pay.status;
   assign cpu_resp_data   = resp_pay.data;
   assign resp_hs         = cpu_resp_valid & cpu_resp_ready;
   assign cfu_resp_ready  = resp_hs ? grant[NUM_CFUS-1:0] : '0;
   assign err_pop         = resp_hs & grant[NUM_CFUS];
   assign grant_valid     = |(grant & src_valid);

   // A grant the core stalls on is frozen until the core takes it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:   if (any_valid && !cpu_resp_ready) state_d = ARB_LOCKED;
         ARB_LOCKED: if (cpu_resp_ready) state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         count_q  <= '0;
         err_full <= 1'b0;
         err_q    <= '0;
      end else begin
         assert (!(resp_hs && !req_hs && count_q == '0));
         assert (!(req_hs && !resp_hs && count_q == CW'(MAX_OUTSTANDING)));
         assert (!(locked && !grant_valid));
         state_q <= state_d;
         if (req_hs && !resp_hs) count_q <= count_q + CW'(1);
         else if (!req_hs && resp_hs) count_q <= count_q - CW'(1);
         // Pop then load: a load in the same cycle wins.
         if (err_load) begin
            err_full <= 1'b1;
            err_q    <= '{id: cpu_req_id, status: CFU_STATUS_ERROR, data: '0};
         end else if (err_pop) begin
            err_full <= 1'b0;
         end
      end
   end

   assign dbg_state = state_q;
   assign dbg_count = count_q;

endmodule

// File: tb/tb_cfu_arbiter.sv
// Directed bench for cfu_arbiter with NUM_CFUS=4, MAX_OUTSTANDING=4.
module tb_cfu_arbiter;
   import cfu_types::*;

   logic                        clk;
   logic                        rst;
   logic                        cpu_req_valid;
   logic                        cpu_req_ready;
   logic [C_M_CFU_ID_W-1:0]     cpu_req_id;
   logic [C_M_CFU_CFU_W-1:0]    cpu_req_cfu;
   logic [C_M_CFU_STATE_W-1:0]  cpu_req_state;
   logic [C_M_CFU_FUNC_W-1:0]   cpu_req_func;
   logic [C_M_CFU_INSN_W-1:0]   cpu_req_insn;
   logic [C_M_CFU_DATA_W-1:0]   cpu_req_data0;
   logic [C_M_CFU_DATA_W-1:0]   cpu_req_data1;
   logic                        cpu_resp_valid;
   logic                        cpu_resp_ready;
   logic [C_M_CFU_ID_W-1:0]     cpu_resp_id;
   logic [C_M_CFU_STATUS_W-1:0] cpu_resp_status;
   logic [C_M_CFU_DATA_W-1:0]   cpu_resp_data;
   logic [3:0]                  cfu_req_valid;
   logic [3:0]                  cfu_req_ready;
   cfu_req_t                    cfu_req_payload;
   logic [3:0]                  cfu_resp_valid;
   logic [3:0]                  cfu_resp_ready;
   cfu_resp_t                   resp_pay [4];
   arb_state_t                  dbg_state;
   logic [2:0]                  dbg_count;
   logic [2:0]                  dbg_ptr;

   int nvec = 0;
   int nerr = 0;

   cfu_arbiter #(.NUM_CFUS(4), .MAX_OUTSTANDING(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .cpu_req_valid    (cpu_req_valid),
      .cpu_req_ready    (cpu_req_ready),
      .cpu_req_id       (cpu_req_id),
      .cpu_req_cfu      (cpu_req_cfu),
      .cpu_req_state    (cpu_req_state),
      .cpu_req_func     (cpu_req_func),
      .cpu_req_insn     (cpu_req_insn),
      .cpu_req_data0    (cpu_req_data0),
      .cpu_req_data1    (cpu_req_data1),
      .cpu_resp_valid   (cpu_resp_valid),
      .cpu_resp_ready   (cpu_resp_ready),
      .cpu_resp_id      (cpu_resp_id),
      .cpu_resp_status  (cpu_resp_status),
      .cpu_resp_data    (cpu_resp_data),
      .cfu_req_valid    (cfu_req_valid),
      .cfu_req_ready    (cfu_req_ready),
      .cfu_req_payload  (cfu_req_payload),
      .cfu_resp_valid   (cfu_resp_valid),
      .cfu_resp_ready   (cfu_resp_ready),
      .cfu_resp_payload (resp_pay),
      .dbg_state        (dbg_state),
      .dbg_count        (dbg_count),
      .dbg_ptr          (dbg_ptr)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_resp(input int i, input logic [3:0] id, input logic [31:0] data);
      resp_pay[i] = '{id: id, status: CFU_STATUS_OK, data: data};
   endtask

   initial begin
      // reset with every input trying to provoke activity
      rst            = 1'b1;
      cpu_req_valid  = 1'b1;
      cpu_req_id     = 4'd0;
      cpu_req_cfu    = 3'd0;
      cpu_req_state  = 2'd0;
      cpu_req_func   = 7'd0;
      cpu_req_insn   = 32'h0;
      cpu_req_data0  = 32'h0;
      cpu_req_data1  = 32'h0;
      cpu_resp_ready = 1'b1;
      cfu_req_ready  = 4'hF;
      cfu_resp_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_resp(i, 4'd0, 32'h0);
      step();
      step();
      #1;
      chk("rst_req_ready", 64'(cpu_req_ready), 64'd0);
      chk("rst_resp_valid", 64'(cpu_resp_valid), 64'd0);
      chk("rst_cfu_req_valid", 64'(cfu_req_valid), 64'd0);
      chk("rst_cfu_resp_ready", 64'(cfu_resp_ready), 64'd0);
      rst            = 1'b0;
      cpu_req_valid  = 1'b0;
      cfu_resp_valid = 4'h0;
      cfu_req_ready  = 4'h0;
      #1;
      chk("rst_count", 64'(dbg_count), 64'd0);
      chk("rst_ptr", 64'(dbg_ptr), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
      chk("rst_idle_resp_valid", 64'(cpu_resp_valid), 64'd0);

      // 1: single request to CFU2, answered 3 cycles later
      step();
      cpu_req_valid = 1'b1;
      cpu_req_cfu   = 3'd2;
      cpu_req_func  = 7'd5;
      cpu_req_id    = 4'd7;
      cfu_req_ready = 4'b0100;
      #1;
      chk("t1_cfu_req_valid", 64'(cfu_req_valid), 64'b0100);
      chk("t1_req_ready", 64'(cpu_req_ready), 64'd1);
      chk("t1_payload_func", 64'(cfu_req_payload.func), 64'd5);
      step();
      cpu_req_valid = 1'b0;
      #1;
      chk("t1_count_1", 64'(dbg_count), 64'd1);
      step();
      step();
      set_resp(2, 4'd7, 32'hA5A5);
      cfu_resp_valid = 4'b0100;
      #1;
      chk("t1_resp_valid", 64'(cpu_resp_valid), 64'd1);
      chk("t1_resp_id", 64'(cpu_resp_id), 64'd7);
      chk("t1_resp_status", 64'(cpu_resp_status), 64'd0);
      chk("t1_resp_data", 64'(cpu_resp_data), 64'hA5A5);
      chk("t1_cfu_resp_ready", 64'(cfu_resp_ready), 64'b0100);
      step();
      cfu_resp_valid = 4'h0;
      #1;
      chk("t1_count_0", 64'(dbg_count), 64'd0);
      chk("t1_ptr", 64'(dbg_ptr), 64'd3);

      // 2: outstanding cap
      cpu_req_valid = 1'b1;
      cpu_req_cfu   = 3'd0;
      cfu_req_ready = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_req_ready_room", 64'(cpu_req_ready), 64'd1);
         step();
      end
      #1;
      chk("t2_req_ready_full", 64'(cpu_req_ready), 64'd0);
      chk("t2_cfu_req_valid_full", 64'(cfu_req_valid), 64'd0);
      chk("t2_count_4", 64'(dbg_count), 64'd4);
      set_resp(1, 4'd1, 32'h11);
      cfu_resp_valid = 4'b0010;
      #1;
      chk("t2_cfu_resp_ready", 64'(cfu_resp_ready), 64'b0010);
      chk("t2_req_ready_still_full", 64'(cpu_req_ready), 64'd0);
      step();
      cfu_resp_valid = 4'h0;
      #1;
      chk("t2_count_3", 64'(dbg_count), 64'd3);
      chk("t2_req_ready_after", 64'(cpu_req_ready), 64'd1);
      chk("t2_cfu_req_valid_after", 64'(cfu_req_valid), 64'b0001);
      step();
      cpu_req_valid = 1'b0;
      #1;
      chk("t2_count_refill", 64'(dbg_count), 64'd4);
      chk("t2_ptr", 64'(dbg_ptr), 64'd2);

      // clear the outstanding requests
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_count", 64'(dbg_count), 64'd0);
      chk("mid_rst_ptr", 64'(dbg_ptr), 64'd0);

      // 3: CFU0, CFU1, CFU3 respond together, pointer at 0
      cpu_req_valid = 1'b1;
      cpu_req_cfu   = 3'd0;
      step();
      cpu_req_cfu   = 3'd1;
      step();
      cpu_req_cfu   = 3'd3;
      step();
      cpu_req_valid = 1'b0;
      set_resp(0, 4'hA, 32'h1000_000A);
      set_resp(1, 4'hB, 32'h1000_000B);
      set_resp(3, 4'hD, 32'h1000_000D);
      cfu_resp_valid = 4'b1011;
      #1;
      chk("t3_grant0", 64'(cfu_resp_ready), 64'b0001);
      chk("t3_id0", 64'(cpu_resp_id), 64'hA);
      step();
      cfu_resp_valid = 4'b1010;
      #1;
      chk("t3_grant1", 64'(cfu_resp_ready), 64'b0010);
      chk("t3_id1", 64'(cpu_resp_id), 64'hB);
      step();
      cfu_resp_valid = 4'b1000;
      #1;
      chk("t3_grant3", 64'(cfu_resp_ready), 64'b1000);
      chk("t3_data3", 64'(cpu_resp_data), 64'h1000_000D);
      step();
      cfu_resp_valid = 4'h0;
      #1;
      chk("t3_count", 64'(dbg_count), 64'd0);
      chk("t3_resp_valid_idle", 64'(cpu_resp_valid), 64'd0);
      chk("t3_ptr", 64'(dbg_ptr), 64'd4);

      // 4: CFU1 held under backpressure while CFU0 arrives
      cpu_req_valid = 1'b1;
      cpu_req_cfu   = 3'd1;
      step();
      cpu_req_cfu   = 3'd0;
      step();
      cpu_req_valid  = 1'b0;
      cpu_resp_ready = 1'b0;
      set_resp(1, 4'h5, 32'h1111_0001);
      set_resp(0, 4'h4, 32'h0000_2222);
      cfu_resp_valid = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_hold_id", 64'(cpu_resp_id), 64'h5);
         chk("t4_hold_data", 64'(cpu_resp_data), 64'h1111_0001);
         chk("t4_hold_no_ready", 64'(cfu_resp_ready), 64'd0);
         step();
         cfu_resp_valid = 4'b0011;
      end
      #1;
      chk("t4_state_locked", 64'(dbg_state), 64'(ARB_LOCKED));
      cpu_resp_ready = 1'b1;
      #1;
      chk("t4_first_ready", 64'(cfu_resp_ready), 64'b0010);
      chk("t4_first_id", 64'(cpu_resp_id), 64'h5);
      step();
      cfu_resp_valid = 4'b0001;
      #1;
      chk("t4_second_ready", 64'(cfu_resp_ready), 64'b0001);
      chk("t4_second_id", 64'(cpu_resp_id), 64'h4);
      chk("t4_state_idle", 64'(dbg_state), 64'(ARB_IDLE));
      step();
      cfu_resp_valid = 4'h0;
      #1;
      chk("t4_count", 64'(dbg_count), 64'd0);

      // 5: request to a non-existent CFU
      cpu_resp_ready = 1'b0;
      cpu_req_valid  = 1'b1;
      cpu_req_cfu    = 3'd6;
      cpu_req_id     = 4'd3;
      cfu_req_ready  = 4'hF;
      #1;
      chk("t5_req_ready", 64'(cpu_req_ready), 64'd1);
      chk("t5_no_cfu_valid", 64'(cfu_req_valid), 64'd0);
      step();
      cpu_req_valid = 1'b0;
      #1;
      chk("t5_resp_valid", 64'(cpu_resp_valid), 64'd1);
      chk("t5_resp_id", 64'(cpu_resp_id), 64'd3);
      chk("t5_resp_status", 64'(cpu_resp_status), 64'(CFU_STATUS_ERROR));
      chk("t5_resp_data", 64'(cpu_resp_data), 64'd0);
      chk("t5_count", 64'(dbg_count), 64'd1);
      cpu_resp_ready = 1'b1;
      #1;
      chk("t5_no_cfu_ready", 64'(cfu_resp_ready), 64'd0);
      step();
      #1;
      chk("t5_resp_drained", 64'(cpu_resp_valid), 64'd0);
      chk("t5_ptr", 64'(dbg_ptr), 64'd0);
      chk("t5_count_0", 64'(dbg_count), 64'd0);

      // 6: reset while LOCKED with 3 outstanding
      cpu_req_valid = 1'b1;
      cpu_req_cfu   = 3'd0;
      step();
      cpu_req_cfu   = 3'd1;
      step();
      cpu_req_cfu   = 3'd2;
      step();
      cpu_req_valid = 1'b0;
      set_resp(2, 4'h9, 32'h9);
      cfu_resp_valid = 4'b0100;
      step();
      cfu_resp_valid = 4'h0;
      cpu_req_valid  = 1'b1;
      cpu_req_cfu    = 3'd3;
      step();
      cpu_req_valid  = 1'b0;
      set_resp(0, 4'h8, 32'h8);
      cfu_resp_valid = 4'b0001;
      cpu_resp_ready = 1'b0;
      step();
      #1;
      chk("t6_locked", 64'(dbg_state), 64'(ARB_LOCKED));
      chk("t6_count_3", 64'(dbg_count), 64'd3);
      chk("t6_ptr_3", 64'(dbg_ptr), 64'd3);
      rst = 1'b1;
      #1;
      chk("t6_rst_resp_valid", 64'(cpu_resp_valid), 64'd0);
      step();
      rst            = 1'b0;
      cfu_resp_valid = 4'h0;
      #1;
      chk("t6_count_0", 64'(dbg_count), 64'd0);
      chk("t6_resp_valid", 64'(cpu_resp_valid), 64'd0);
      chk("t6_ptr_0", 64'(dbg_ptr), 64'd0);
      chk("t6_state_idle", 64'(dbg_state), 64'(ARB_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
